fp_decode: RTL

Multi-cycle decoder that turns the lab's 8-bit floating-point format back into a 12-bit two's-complement value. Input fields are sign (1 bit), exponent E (3 bits) and significand F (4 bits). The output is value = (−1)^S · F · 2^E. It is the inverse of the two's-complement-to-float conversion path and sits on the read-back side, feeding displays and checkers. A valid/ready handshake sits on both sides, and the block holds one conversion in flight at a time.

---
 rtl/fp_decode.sv | 88 ++++++++
 1 files changed

// File: rtl/fp_decode.sv
// fp_decode: multi-cycle decoder from the 8-bit float format (S, E[2:0], F[3:0])
// to a 12-bit two's-complement value, value = (-1)^S * F * 2^E.
// One conversion in flight; valid/ready handshake on both sides.
module fp_decode (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        s_in,
   input  logic [2:0]  e_in,
   input  logic [3:0]  f_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] dout
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e      state_q, state_d;
   logic [10:0] mag_q, mag_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        sgn_q, sgn_d;
   logic [11:0] dout_q, dout_d;
   logic        out_valid_q, out_valid_d;

   // Held low while reset is asserted so upstream never sees an accept window then.
   assign in_ready  = (state_q == StIdle) & ~rst;
   assign out_valid = out_valid_q;
   assign dout      = dout_q;

   // Next-state and datapath updates; shift once per cycle until the exponent is used up.
   always_comb begin
      state_d     = state_q;
      mag_d       = mag_q;
      cnt_d       = cnt_q;
      sgn_d       = sgn_q;
      dout_d      = dout_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               mag_d   = {7'b0, f_in};
               cnt_d   = e_in;
               sgn_d   = s_in;
               state_d = StShift;
            end
         end
         StShift: begin
            if (cnt_q != 3'd0) begin
               mag_d = mag_q << 1;
               cnt_d = cnt_q - 3'd1;
            end else begin
               // Negate at 12 bits; negative zero wraps back to 0.
               dout_d      = sgn_q ? (~{1'b0, mag_q} + 12'd1) : {1'b0, mag_q};
               out_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous reset taking priority over any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         mag_q       <= 11'd0;
         cnt_q       <= 3'd0;
         sgn_q       <= 1'b0;
         dout_q      <= 12'h000;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mag_q       <= mag_d;
         cnt_q       <= cnt_d;
         sgn_q       <= sgn_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
